// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: byte-level I2C master driven by a START/STOP/WRITE/READ
// command stream. Each bit is four equal phases (Q0..Q3) of CLK_DIV clocks.
// SCL is push-pull, SDA is open-drain.
module i2c_cmd_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_mack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       SCL,
  inout  wire        SDA
);

  typedef enum logic [2:0] {IDLE, START, STOP, XFER, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] timer;
  logic [1:0] quarter;
  logic [3:0] bit_cnt;
  logic       is_read;
  logic [7:0] wdata;
  logic       mack;
  logic [7:0] rx;
  logic       ack_bit;
  logic       sda_low;

  // Open-drain pad: only ever pull low, otherwise let the bus float.
  assign SDA  = sda_low ? 1'b0 : 1'bz;
  assign busy = !cmd_ready;

  // Level the master puts on SDA for a given bit of a transfer (1 = release).
  // WRITE sends the byte MSB first then releases for the slave ACK;
  // READ releases for the slave data then drives the master ACK/NACK.
  function automatic logic xfer_level(input logic rd, input logic [7:0] wd,
                                      input logic mk, input logic [3:0] b);
    if (b == 4'd8) return rd ? mk : 1'b1;
    return rd ? 1'b1 : wd[3'd7 - b[2:0]];
  endfunction

  // Command FSM, phase timer and pin/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      wdata     <= '0;
      mack      <= 1'b0;
      rx        <= '0;
      ack_bit   <= 1'b0;
      SCL       <= 1'b1;
      sda_low   <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (cmd_valid && cmd_ready) begin
            // Every command starts in Q0 with SCL low.
            timer     <= '0;
            quarter   <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            SCL       <= 1'b0;
            is_read   <= cmd_op[0];
            wdata     <= cmd_wdata;
            mack      <= cmd_mack;
            case (cmd_op)
              2'b00: begin
                state   <= START;
                sda_low <= 1'b0;
              end
              2'b01: begin
                state   <= STOP;
                sda_low <= 1'b1;
              end
              default: begin
                state   <= XFER;
                sda_low <= !xfer_level(cmd_op[0], cmd_wdata, cmd_mack, 4'd0);
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (timer != TIMER_LAST) begin
            timer <= timer + 8'd1;
          end else begin
            timer <= '0;
            // Sample SDA on the last edge of Q2, in the middle of SCL high.
            if (state == XFER && quarter == 2'd2) begin
              if (is_read && bit_cnt != 4'd8) rx <= {rx[6:0], SDA};
              if (!is_read && bit_cnt == 4'd8) ack_bit <= SDA;
            end
            if (quarter != 2'd3) begin
              quarter <= quarter + 2'd1;
              if (quarter == 2'd1) SCL <= 1'b1;
              if (quarter == 2'd2) begin
                // The only edge where SDA moves under SCL high.
                if (state == START) sda_low <= 1'b1;
                if (state == STOP)  sda_low <= 1'b0;
              end
            end else if (state == XFER && bit_cnt != 4'd8) begin
              quarter <= '0;
              bit_cnt <= bit_cnt + 4'd1;
              SCL     <= 1'b0;
              sda_low <= !xfer_level(is_read, wdata, mack, bit_cnt + 4'd1);
            end else begin
              // Pins keep their Q3 levels until the next command.
              state     <= RESP;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              if (state == XFER) begin
                if (is_read) rsp_rdata <= rx;
                else         rsp_nack  <= ack_bit;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Testbench for i2c_cmd_master: a cycle-offset model of the bus waveform and
// responses, a simple slave, per-cycle comparison, and literal spot checks.
module tb_i2c_cmd_master;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       cmd_mack;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl;
  wire        sda;

  int n_checks = 0;
  int n_errors = 0;

  // Slave behaviour for the next command (latched by the model on accept).
  logic       sl_ack;
  logic [7:0] sl_byte;

  // Model state.
  logic       m_active, m_ready, m_rsp, m_scl, m_sda, m_nack;
  logic [7:0] m_rdata;
  int         m_k, m_len;
  logic [1:0] m_op;
  logic [7:0] m_wdata, m_sbyte;
  logic       m_mack, m_sack;
  logic       slave_low;

  logic scl_obs [0:255];
  logic sda_obs [0:255];

  i2c_cmd_master #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .cmd_mack  (cmd_mack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .SCL       (scl),
    .SDA       (sda)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected {SCL, SDA-release} at cycle offset k of a command.
  function automatic logic [1:0] pins(input logic [1:0] op, input logic [7:0] wd,
                                      input logic mk, input int k);
    int q, b;
    logic c, d;
    q = (k / DIV) % 4;
    b = k / (4 * DIV);
    c = (q >= 2);
    case (op)
      2'd0:    d = (q != 3);
      2'd1:    d = (q == 3);
      2'd2:    d = (b < 8) ? wd[7 - (b % 8)] : 1'b1;
      default: d = (b < 8) ? 1'b1 : mk;
    endcase
    return {c, d};
  endfunction

  // Slave pulls SDA for its ACK (WRITE bit 8) or its zero data bits (READ 0..7).
  function automatic logic slave_pull(input logic act, input logic [1:0] op, input int k,
                                      input logic sack, input logic [7:0] sbyte);
    int b;
    b = k / (4 * DIV);
    if (!act || !op[1]) return 1'b0;
    if (op == 2'd2) return (b == 8) && sack;
    return (b < 8) && !sbyte[7 - (b % 8)];
  endfunction

  assign slave_low = slave_pull(m_active, m_op, m_k, m_sack, m_sbyte);

  // Behavioural model: a command is a run of 4*DIV or 36*DIV cycles indexed by offset k.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_ready  <= 1'b1;
      m_rsp    <= 1'b0;
      m_scl    <= 1'b1;
      m_sda    <= 1'b1;
      m_rdata  <= 8'h00;
      m_nack   <= 1'b0;
      m_k      <= 0;
      m_len    <= 0;
      m_op     <= 2'd0;
      m_wdata  <= 8'h00;
      m_mack   <= 1'b0;
      m_sack   <= 1'b0;
      m_sbyte  <= 8'h00;
    end else begin
      m_rsp <= 1'b0;
      if (m_active) begin
        if (m_k + 1 == m_len) begin
          m_active <= 1'b0;
          m_rsp    <= 1'b1;
          m_ready  <= 1'b1;
          if (m_op == 2'd3) m_rdata <= m_sbyte;
          if (m_op == 2'd2) m_nack  <= !m_sack;
        end else begin
          m_k <= m_k + 1;
          {m_scl, m_sda} <= pins(m_op, m_wdata, m_mack, m_k + 1);
        end
      end else if (m_ready && cmd_valid) begin
        m_active <= 1'b1;
        m_ready  <= 1'b0;
        m_k      <= 0;
        m_len    <= (cmd_op[1] ? 36 : 4) * DIV;
        m_op     <= cmd_op;
        m_wdata  <= cmd_wdata;
        m_mack   <= cmd_mack;
        m_sack   <= sl_ack;
        m_sbyte  <= sl_byte;
        {m_scl, m_sda} <= pins(cmd_op, cmd_wdata, cmd_mack, 0);
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    check("scl", scl, m_scl);
    check("sda", sda, m_sda & !slave_low);
    check("cmd_ready", cmd_ready, m_ready);
    check("busy", busy, !m_ready);
    check("rsp_valid", rsp_valid, m_rsp);
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("rsp_nack", rsp_nack, m_nack);
  end

  // Issue one command (entered and left on a negedge); lat = cycles from accept to rsp_valid.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input logic mk,
                        input logic sack, input logic [7:0] sbyte, output int lat);
    int guard;
    int cnt;
    sl_ack  = sack;
    sl_byte = sbyte;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    cmd_mack  = mk;
    @(negedge clk);
    cnt = 1;
    while (cnt < 200) begin
      scl_obs[cnt] = scl;
      sda_obs[cnt] = sda;
      if (rsp_valid) break;
      // Traffic while busy must be ignored.
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom);
      cmd_wdata = 8'($urandom);
      cmd_mack  = 1'($urandom);
      @(negedge clk);
      cnt++;
    end
    cmd_valid = 1'b0;
    if (cnt >= 200) check("rsp_timeout", 0, 1);
    lat = cnt;
    $display("cmd op=%0d wd=%02h mk=%0d sack=%0d sbyte=%02h lat=%0d rdata=%02h nack=%0d",
             op, wd, mk, sack, sbyte, lat, rsp_rdata, rsp_nack);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] v;
    logic [1:0] op;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_wdata = 8'h00;
    cmd_mack = 1'b0;
    sl_ack = 1'b0;
    sl_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // START: SDA falls under SCL high at cycle 7, response at cycle 9.
    do_cmd(2'd0, 8'h00, 1'b0, 1'b0, 8'h00, lat);
    check("start_lat", lat, 9);
    check("start_c6_sda", sda_obs[6], 1'b1);
    check("start_c7_scl", scl_obs[7], 1'b1);
    check("start_c7_sda", sda_obs[7], 1'b0);

    // STOP back-to-back: SDA rises under SCL high.
    do_cmd(2'd1, 8'h00, 1'b0, 1'b0, 8'h00, lat);
    check("stop_lat", lat, 9);
    check("stop_c6_sda", sda_obs[6], 1'b0);
    check("stop_c7_scl", scl_obs[7], 1'b1);
    check("stop_c7_sda", sda_obs[7], 1'b1);

    // WRITE 0xA5 acknowledged.
    do_cmd(2'd2, 8'hA5, 1'b0, 1'b1, 8'h00, lat);
    for (int b = 0; b < 8; b++) v[7 - b] = sda_obs[b * 4 * DIV + 2 * DIV + 1];
    check("wr_a5_bits", v, 8'hA5);
    check("wr_a5_ack_sda", sda_obs[8 * 4 * DIV + 2 * DIV + 1], 1'b0);
    check("wr_a5_lat", lat, 73);
    check("wr_a5_nack", rsp_nack, 1'b0);

    // WRITE 0x3C with nobody answering.
    do_cmd(2'd2, 8'h3C, 1'b0, 1'b0, 8'h00, lat);
    check("wr_3c_nack", rsp_nack, 1'b1);

    // READ 0x5E, master NACKs.
    do_cmd(2'd3, 8'h00, 1'b1, 1'b0, 8'h5E, lat);
    check("rd_5e_bit8_sda", sda_obs[8 * 4 * DIV + 2 * DIV + 1], 1'b1);
    check("rd_5e_rdata", rsp_rdata, 8'h5E);
    check("rd_5e_nack_kept", rsp_nack, 1'b1);

    // Random command stream with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      do_cmd(op, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), lat);
      check("rand_lat", lat, (op[1] ? 36 : 4) * DIV + 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a READ, at bit 4 Q2.
    sl_byte = 8'hA1;
    sl_ack = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_mack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4 * 4 * DIV + 2 * DIV) @(negedge clk);
    check("pre_rst_scl", scl, 1'b1);
    check("pre_rst_sda", sda, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda", sda, 1'b1);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(2'd0, 8'h00, 1'b0, 1'b0, 8'h00, lat);
    check("post_rst_start_lat", lat, 9);
    check("post_rst_start_c7_sda", sda_obs[7], 1'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
